// File: rtl/adc_spi_sampler_if.sv
// Sampler bundle: enable input, ADC serial pins, sample output and status flags.
interface adc_spi_sampler_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic                    en;
  logic                    adc_miso;
  logic                    adc_cs_n;
  logic                    adc_sclk;
  logic signed [WIDTH-1:0] samp;
  logic                    samp_stb;
  logic                    busy;
  logic                    ovr;

  // Sampler side: drives the ADC pins and the sample/status outputs.
  modport master (
    input  en, adc_miso,
    output adc_cs_n, adc_sclk, samp, samp_stb, busy, ovr
  );

  // Environment side: supplies enable and ADC data, consumes samples.
  modport slave (
    output en, adc_miso,
    input  adc_cs_n, adc_sclk, samp, samp_stb, busy, ovr
  );
endinterface

// File: rtl/adc_spi_sampler.sv
// Periodic serial-ADC reader: tick -> conversion wait -> MSB-first shift -> signed sample strobe.
module adc_spi_sampler #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CONV_CYC   = 100,
  parameter int unsigned SAMP_DIV   = 1000,
  parameter bit          OFFSET_BIN = 1'b1
) (
  input logic               clk,
  input logic               nrst,
  adc_spi_sampler_if.master bus
);

  localparam int unsigned PerW   = (SAMP_DIV > 1) ? $clog2(SAMP_DIV) : 1;
  localparam int unsigned DivTop = (CONV_CYC > CLK_DIV) ? CONV_CYC : CLK_DIV;
  localparam int unsigned DivW   = (DivTop > 1) ? $clog2(DivTop) : 1;
  localparam int unsigned BitW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [PerW-1:0] PerMax  = PerW'(SAMP_DIV - 1);
  localparam logic [DivW-1:0] ConvMax = DivW'(CONV_CYC - 1);
  localparam logic [DivW-1:0] HalfMax = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitMax  = BitW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StConv, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [PerW-1:0]    per_q, per_d;
  logic               en_q;
  logic               tick;
  logic [DivW-1:0]    div_q, div_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic               sclk_q, sclk_d;
  logic               cs_n_q, cs_n_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   samp_q, samp_d;
  logic [WIDTH-1:0]   conv;
  logic               stb_q, stb_d;
  logic               busy_q, busy_d;
  logic               ovr_q, ovr_d;

  // Period counter: parked at zero while disabled; en_q delays the start by one cycle so the
  // first tick lands SAMP_DIV cycles after en rises.
  always_comb begin
    per_d = per_q;
    if (!bus.en || !en_q) begin
      per_d = '0;
    end else if (per_q == PerMax) begin
      per_d = '0;
    end else begin
      per_d = per_q + 1'b1;
    end
  end

  // Raw en gates the tick so a tick coinciding with en falling is ignored.
  assign tick = bus.en && en_q && (per_q == PerMax);

  // Offset-binary codes become two's complement by flipping the sign bit.
  always_comb begin
    conv = shift_q;
    if (OFFSET_BIN) begin
      conv[WIDTH-1] = ~shift_q[WIDTH-1];
    end
  end

  // Frame sequencer: next state plus next value of every registered output.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = 1'b0;
    cs_n_d  = 1'b1;
    shift_d = shift_q;
    samp_d  = samp_q;
    stb_d   = 1'b0;
    ovr_d   = ovr_q;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StConv;
          div_d   = '0;
          cs_n_d  = 1'b0;
        end
      end
      StConv: begin
        cs_n_d = 1'b0;
        if (div_q == ConvMax) begin
          state_d = StShift;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StShift: begin
        cs_n_d = 1'b0;
        sclk_d = sclk_q;
        if (div_q == HalfMax) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Capture on the edge that raises sclk.
            shift_d = {shift_q[WIDTH-2:0], bus.adc_miso};
          end else if (bit_q == BitMax) begin
            state_d = StDone;
            samp_d  = conv;
            stb_d   = 1'b1;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // A tick is never queued; landing while a frame is in flight only flags overrun.
    if (tick && (state_q != StIdle)) begin
      ovr_d = 1'b1;
    end
    if (!bus.en) begin
      ovr_d = 1'b0;
    end
  end

  assign busy_d = (state_d != StIdle);

  // Period counter and enable delay registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      per_q <= '0;
      en_q  <= 1'b0;
    end else begin
      per_q <= per_d;
      en_q  <= bus.en;
    end
  end

  // Frame state and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      shift_q <= '0;
      samp_q  <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      shift_q <= shift_d;
      samp_q  <= samp_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.adc_cs_n = cs_n_q;
  assign bus.adc_sclk = sclk_q;
  assign bus.samp     = samp_q;
  assign bus.samp_stb = stb_q;
  assign bus.busy     = busy_q;
  assign bus.ovr      = ovr_q;

endmodule
